// File: rtl/and4_vector_sequencer.sv
// and4_vector_sequencer: self-test stage for a 4-input AND gate.
// It steps a,b,c,d through all 16 vectors, counting up from 0 (a = LSB). Each
// vector is held for HOLD_CYCLES cycles, and f_in is compared against a&b&c&d
// in the last cycle of each hold.
// Optional build macro AND4_VECTOR_SEQ_FIRST_FAIL_EN adds fail_vec/fail_seen,
// which capture the first mismatching vector of a run.
//
// Handshake: start is a request with no acknowledge. It is acted on only when
// the sequencer is in IDLE. In any other state it is ignored, and it is never
// queued. If start is held high, a new run is accepted on every IDLE cycle.
module and4_vector_sequencer #(
  parameter int unsigned HOLD_CYCLES = 5   // legal range 2..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [1:0] state_dbg
`ifdef AND4_VECTOR_SEQ_FIRST_FAIL_EN
  ,
  output logic [3:0] fail_vec,
  output logic       fail_seen
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // HOLD lasts HOLD_CYCLES-1 cycles; the CHECK cycle completes the hold.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 2);

  logic [1:0] state;
  logic [7:0] hold_cnt;
  logic [3:0] vec;
  logic       mismatch;
  logic [4:0] err_next;

  // Compare happens only in CHECK, after f_in has had HOLD_CYCLES-1 cycles to settle.
  assign mismatch = (state == ST_CHECK) && (f_in != (&vec));
  assign err_next = err_count + {4'd0, mismatch};

  assign a         = vec[0];
  assign b         = vec[1];
  assign c         = vec[2];
  assign d         = vec[3];
  assign state_dbg = state;

  // Main sequencer: vector stepping, hold timing, mismatch count and run status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= 8'd0;
      vec       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          vec <= 4'd0;
          if (start) begin
            state     <= ST_HOLD;
            hold_cnt  <= 8'd0;
            err_count <= 5'd0;
            pass      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_HOLD: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (hold_cnt == HOLD_LAST) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_count <= err_next;
          if (vec != 4'hF) begin
            vec      <= vec + 4'd1;
            hold_cnt <= 8'd0;
            state    <= ST_HOLD;
          end else begin
            state <= ST_FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 5'd0);
          end
        end
        ST_FINISH: begin
          vec   <= 4'd0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef AND4_VECTOR_SEQ_FIRST_FAIL_EN
  // First-failure capture: cleared when a run starts, written only on the first mismatch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_vec  <= 4'd0;
      fail_seen <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      fail_vec  <= 4'd0;
      fail_seen <= 1'b0;
    end else if (mismatch && !fail_seen) begin
      fail_vec  <= vec;
      fail_seen <= 1'b1;
    end
  end
`endif

endmodule
